// File: rtl/qr_pkg.sv
// qr_pkg: shared frame geometry, sample field slices and streamer state encoding.
package qr_pkg;
    localparam int WORDS_PER_ROW   = 5;
    localparam int ROWS            = 4;
    localparam int WORDS_PER_GROUP = 20;
    localparam int WORDS_PER_FRAME = 200;
    localparam int IMAG_HI = 47;
    localparam int IMAG_LO = 24;
    localparam int REAL_HI = 23;
    localparam int REAL_LO = 0;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_WAIT} state_t;
endpackage

// File: rtl/qr_addr_gen.sv
// qr_addr_gen: walks a stored column-major frame in row-major order (H row then y)
// and keeps the frame base as a running sum so no multiplier is needed.
module qr_addr_gen
    import qr_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int GROUPS = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              clr,
    input  logic              step,
    input  logic              next_frame,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(GROUPS * WORDS_PER_GROUP);
    logic [GW-1:0]     g;
    logic [1:0]        row;
    logic [2:0]        col;
    logic [ADDR_W-1:0] base;
    logic [4:0]        word;
    logic              row_end;
    // col 4 is the y entry stored after the 16 H words of the group
    always_comb begin
        row_end = col == 3'(WORDS_PER_ROW - 1);
        word    = row_end ? {3'b100, row} : {1'b0, col[1:0], row};
        addr    = base + ADDR_W'(g) * ADDR_W'(WORDS_PER_GROUP) + ADDR_W'(word);
        last    = row_end && row == 2'(ROWS - 1) && g == GW'(GROUPS - 1);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            g    <= '0;
            row  <= '0;
            col  <= '0;
            base <= '0;
        end else if (clr) begin
            g    <= '0;
            row  <= '0;
            col  <= '0;
            base <= '0;
        end else begin
            if (step) begin
                col <= row_end ? 3'd0 : col + 3'd1;
                if (row_end) begin
                    row <= row + 2'd1;
                    if (row == 2'(ROWS - 1))
                        g <= last ? '0 : g + GW'(1);
                end
            end
            if (next_frame)
                base <= base + FRAME_STEP;
        end
    end
endmodule

// File: rtl/qr_frame_streamer.sv
// qr_frame_streamer: replays stored channel frames as the QR engine's trig/data burst
// and supervises the per-frame result handshake.
module qr_frame_streamer
    import qr_pkg::*;
#(
    parameter int DATA_W  = 48,
    parameter int ADDR_W  = 16,
    parameter int GROUPS  = WORDS_PER_FRAME / WORDS_PER_GROUP,
    parameter int TIMEOUT = 4095
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_num_frames,
    output logic              o_mem_cen,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_q,
    output logic              o_trig,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_rd_vld,
    input  logic              i_last_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_timeout,
    output logic              o_err_count,
    output logic [7:0]        o_frame_idx
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t          state, state_nx;
    logic [7:0]      n_frames;
    logic            rd_v;
    logic [3:0]      vcnt;
    logic [TW-1:0]   tcnt;
    logic            last_word, last_ok, more, timeout_hit;
    logic            run_start, in_idle, in_wait, streaming, next_frame;

    qr_addr_gen #(.ADDR_W(ADDR_W), .GROUPS(GROUPS)) u_addr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .clr        (run_start),
        .step       (state == S_FETCH),
        .next_frame (next_frame),
        .addr       (o_mem_addr),
        .last       (last_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // SEND only drains the two-stage read pipeline
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (i_start && i_num_frames != 8'd0) state_nx = S_FETCH;
            S_FETCH: if (last_word) state_nx = S_SEND;
            S_SEND:  if (!rd_v) state_nx = S_WAIT;
            S_WAIT:  if (i_last_data) state_nx = more ? S_FETCH : S_IDLE;
                     else if (timeout_hit) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_idle     = state == S_IDLE;
        in_wait     = state == S_WAIT;
        streaming   = state == S_FETCH || state == S_SEND;
        o_mem_cen   = state != S_FETCH;
        o_busy      = !in_idle;
        run_start   = in_idle && i_start && i_num_frames != 8'd0;
        more        = o_frame_idx != n_frames - 8'd1;
        timeout_hit = tcnt == TW'(TIMEOUT - 1);
        last_ok     = (vcnt == 4'd10 && !i_rd_vld) || (vcnt == 4'd9 && i_rd_vld);
        next_frame  = in_wait && i_last_data && more;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_v   <= 1'b0;
            o_trig <= 1'b0;
            o_data <= '0;
        end else begin
            rd_v   <= !o_mem_cen;
            o_trig <= rd_v;
            o_data <= rd_v ? i_mem_q : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            n_frames      <= '0;
            o_frame_idx   <= '0;
            o_done        <= 1'b0;
            o_err_timeout <= 1'b0;
            o_err_count   <= 1'b0;
            vcnt          <= '0;
            tcnt          <= '0;
        end else begin
            o_done <= (in_idle && i_start && i_num_frames == 8'd0) ||
                      (in_wait && (i_last_data ? !more : timeout_hit));
            if (run_start) begin
                n_frames      <= i_num_frames;
                o_frame_idx   <= '0;
                o_err_timeout <= 1'b0;
                o_err_count   <= 1'b0;
            end
            if ((streaming && (i_rd_vld || i_last_data)) || (in_wait && i_last_data && !last_ok))
                o_err_count <= 1'b1;
            if (in_wait && !i_last_data && timeout_hit)
                o_err_timeout <= 1'b1;
            if (next_frame)
                o_frame_idx <= o_frame_idx + 8'd1;
            vcnt <= in_wait ? vcnt + {3'b0, i_rd_vld && vcnt != 4'hf} : 4'd0;
            tcnt <= in_wait ? tcnt + TW'(1) : '0;
        end
    end
endmodule

// File: tb/tb_qr_frame_streamer.sv
// tb_qr_frame_streamer: random frame runs against a memory/engine model and an
// address-formula reference of the replay order.
module tb_qr_frame_streamer;
    localparam int M_NORM = 0, M_SHORT = 1, M_SILENT = 2;
    logic        clk, rst_n, i_start, o_mem_cen, o_trig, i_rd_vld, i_last_data;
    logic        o_busy, o_done, o_err_timeout, o_err_count;
    logic [7:0]  i_num_frames, o_frame_idx;
    logic [15:0] o_mem_addr;
    logic [47:0] i_mem_q, o_data;
    logic [47:0] mem [0:1023];
    logic [47:0] fw [0:199];
    logic [47:0] expw [$];
    logic [7:0]  expf [$];
    int vecs = 0, errs = 0;
    int mode = M_NORM, cen_total, trig_total, done_cnt, burst_len, wait_k, to_k, done_k;
    bit glitch = 0, rand_mem = 0, prev_trig, in_wait;

    qr_frame_streamer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_num_frames(i_num_frames),
        .o_mem_cen(o_mem_cen), .o_mem_addr(o_mem_addr), .i_mem_q(i_mem_q),
        .o_trig(o_trig), .o_data(o_data), .i_rd_vld(i_rd_vld), .i_last_data(i_last_data),
        .o_busy(o_busy), .o_done(o_done), .o_err_timeout(o_err_timeout),
        .o_err_count(o_err_count), .o_frame_idx(o_frame_idx)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stored layout is column-major per group; the stream is row-major with y last.
    function automatic int exp_addr(int f, int i);
        int g = i / 20, r = (i % 20) / 5, c = i % 5;
        return f * 200 + g * 20 + (c < 4 ? c * 4 + r : 16 + r);
    endfunction

    function automatic logic [47:0] memword(int a);
        return rand_mem ? mem[a % 1024] : 48'(a);
    endfunction

    always @(posedge clk) if (!o_mem_cen) i_mem_q <= memword(int'(o_mem_addr));

    // Engine model: after each burst returns 10 (or 9) rd_vld with last_data on the final one.
    initial begin
        int left = 0, gap = 0, etr = 0;
        bit eprev = 0;
        i_rd_vld = 0;
        i_last_data = 0;
        forever begin
            @(negedge clk);
            i_rd_vld = 0;
            i_last_data = 0;
            if (!rst_n) begin
                left = 0; eprev = 0; etr = 0;
            end else begin
                etr = o_trig ? etr + 1 : 0;
                if (eprev && !o_trig && mode != M_SILENT) begin
                    left = (mode == M_SHORT) ? 9 : 10;
                    gap = $urandom_range(0, 4);
                end else if (left > 0) begin
                    if (gap > 0) gap--;
                    else begin
                        i_rd_vld = 1;
                        i_last_data = (left == 1);
                        left--;
                        gap = $urandom_range(0, 3);
                    end
                end
                if (glitch && o_trig && etr == 100) begin
                    i_rd_vld = 1;
                    glitch = 0;
                end
                eprev = o_trig;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            expw.delete(); expf.delete();
            prev_trig = 0; burst_len = 0; in_wait = 0;
        end else begin
            if (!o_mem_cen) cen_total++;
            if (o_done) done_cnt++;
            if (o_trig) begin
                trig_total++;
                if (burst_len < 200) fw[burst_len] = o_data;
                if (expw.size() == 0) chk("unexpected_trig", o_trig, 0);
                else begin
                    chk("data", o_data, expw.pop_front());
                    chk("frame_idx", o_frame_idx, expf.pop_front());
                end
                burst_len++;
                in_wait = 0;
            end else begin
                chk("idle_data", o_data, 0);
                if (prev_trig) begin
                    chk("burst_len", burst_len, 200);
                    burst_len = 0; in_wait = 1; wait_k = 0;
                end
                if (in_wait) begin
                    if (o_err_timeout && to_k < 0) to_k = wait_k;
                    if (o_done && done_k < 0) done_k = wait_k;
                    wait_k++;
                end
            end
            prev_trig = o_trig;
        end
    end

    task automatic push_frames(input int sent);
        for (int f = 0; f < sent; f++)
            for (int i = 0; i < 200; i++) begin
                expw.push_back(memword(exp_addr(f, i)));
                expf.push_back(8'(f));
            end
    endtask

    task automatic run(input int n, input int md, input bit gl, input bit rnd);
        int sent, t;
        sent = (md == M_SILENT) ? 1 : n;
        rand_mem = rnd; mode = md; glitch = gl;
        push_frames(sent);
        done_cnt = 0; trig_total = 0; cen_total = 0; to_k = -1; done_k = -1;
        @(negedge clk);
        i_start = 1; i_num_frames = 8'(n);
        @(posedge clk); #1;
        i_start = 0; i_num_frames = 8'($urandom);
        chk("lat_cen", o_mem_cen, 0);
        chk("lat_addr", o_mem_addr, 0);
        chk("busy", o_busy, 1);
        @(posedge clk); #1 chk("lat_trig2", o_trig, 0);
        @(posedge clk); #1 chk("lat_trig3", o_trig, 1);
        chk("first_word", o_data, memword(0));
        @(negedge clk);
        i_start = 1; i_num_frames = 8'($urandom_range(1, 255));
        @(negedge clk) i_start = 0;
        t = 0;
        while (done_cnt == 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done_cnt != 0, 1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("busy_end", o_busy, 0);
        chk("err_count", o_err_count, (md == M_SHORT) || gl);
        chk("err_timeout", o_err_timeout, md == M_SILENT);
        chk("trig_cycles", trig_total, 200 * sent);
        chk("mem_reads", cen_total, 200 * sent);
        chk("words_left", expw.size(), 0);
        chk("last_idx", o_frame_idx, sent - 1);
        if (md == M_SILENT) begin
            chk("timeout_cycle", to_k, 4095);
            chk("timeout_done", done_k, 4095);
        end
    endtask

    initial begin
        int t;
        for (int i = 0; i < 1024; i++) mem[i] = 48'({$urandom(), $urandom()});
        rst_n = 0; i_start = 0; i_num_frames = 0;
        #1;
        chk("rst_trig", o_trig, 0);
        chk("rst_cen", o_mem_cen, 1);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_data", o_data, 0);
        chk("rst_flags", {o_busy, o_done, o_err_timeout, o_err_count}, 0);
        chk("rst_idx", o_frame_idx, 0);
        #20 rst_n = 1;

        run(1, M_NORM, 0, 0);
        chk("ord0", fw[0], 48'd0);
        chk("ord1", fw[1], 48'd4);
        chk("ord3", fw[3], 48'd12);
        chk("ord4", fw[4], 48'd16);
        chk("ord5", fw[5], 48'd1);
        chk("ord20", fw[20], 48'd20);
        chk("ord199", fw[199], 48'd199);

        run(3, M_NORM, 0, 1);
        run(3, M_SHORT, 0, 1);
        run(2, M_NORM, 1, 1);
        run(3, M_SILENT, 0, 1);

        cen_total = 0; done_cnt = 0;
        @(negedge clk);
        i_start = 1; i_num_frames = 0;
        @(posedge clk); #1;
        i_start = 0;
        chk("zero_done", o_done, 1);
        chk("zero_busy", o_busy, 0);
        @(posedge clk); #1 chk("zero_done_pulse", o_done, 0);
        repeat (4) @(negedge clk);
        chk("zero_reads", cen_total, 0);

        mode = M_NORM; glitch = 0; rand_mem = 0;
        push_frames(1);
        @(negedge clk);
        i_start = 1; i_num_frames = 1;
        @(negedge clk) i_start = 0;
        t = 0;
        while (burst_len < 57 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("reach_word57", burst_len, 57);
        #2 rst_n = 0;
        #1;
        chk("arst_trig", o_trig, 0);
        chk("arst_cen", o_mem_cen, 1);
        chk("arst_busy", o_busy, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        run(1, M_NORM, 0, 0);

        for (int k = 0; k < 3; k++) run($urandom_range(1, 4), M_NORM, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
